// File: rtl/coolgirl_pkg.sv
// Shared definitions for the famiclone power-on probe: FSM codes,
// force-mode codes and the layout of the synchronised PPU word.
package coolgirl_pkg;

   localparam logic [1:0] PROBE_INIT = 2'd0;
   localparam logic [1:0] PROBE_RUN  = 2'd1;
   localparam logic [1:0] PROBE_DONE = 2'd2;

   localparam logic [1:0] FORCE_AUTO     = 2'b00;
   localparam logic [1:0] FORCE_ORIG     = 2'b01;
   localparam logic [1:0] FORCE_NEW      = 2'b10;
   localparam logic [1:0] FORCE_AUTO_ALT = 2'b11;

   typedef enum logic [1:0] {
      ST_INIT  = PROBE_INIT,
      ST_PROBE = PROBE_RUN,
      ST_DONE  = PROBE_DONE
   } probe_state_t;

   // PPU pins captured together so the stability check sees one coherent word
   typedef struct packed {
      logic rd;
      logic a13;
      logic not_a13;
   } ppu_word_t;

   // Idle bus: /RD high, /A13 the proper inverse of A13
   localparam ppu_word_t PPU_IDLE = '{rd: 1'b1, a13: 1'b0, not_a13: 1'b1};

   // Only the two explicit codes override the classifier; 00 and 11 both mean auto
   function automatic logic is_forced(input logic [1:0] mode);
      return (mode == FORCE_ORIG) || (mode == FORCE_NEW);
   endfunction

endpackage

// File: rtl/ppu_sync_bus.sv
// Multi-flop synchroniser for a small bus plus a "stable" flag that is
// high when the synchronised word equals the one seen the cycle before.
module ppu_sync_bus #(
   parameter int               WIDTH   = 3,
   parameter int               STAGES  = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             m2,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             stable
);

   logic [STAGES-1:0][WIDTH-1:0] chain;
   logic [WIDTH-1:0]             prev;

   // Shift the raw bus through the chain; prev keeps the last synced word
   always_ff @(posedge m2 or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         prev  <= chain[STAGES-1];
      end
   end

   assign q      = chain[STAGES-1];
   assign stable = (chain[STAGES-1] == prev);

endmodule

// File: rtl/famiclone_probe.sv
// Power-on console probe: grounds CIRAM /CE and /A13 for a fixed window,
// then watches qualified PPU reads to decide whether /A13 tracks ~A13
// (original) or not (new Dendy famiclone).
module famiclone_probe
   import coolgirl_pkg::*;
#(
   parameter int INIT_CYCLES  = 15,
   parameter int WINDOW       = 16,
   parameter int MISMATCH_MIN = 3,
   parameter int LO_MIN       = 1,
   parameter int HI_MIN       = 1,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                         m2,
   input  logic                         rst_n,
   input  logic                         ppu_rd_in,
   input  logic                         ppu_a13,
   input  logic                         ppu_not_a13,
   input  logic                         restart,
   input  logic [1:0]                   force_mode,
   output logic                         ground_req,
   output logic                         done,
   output logic                         new_dendy,
   output logic [$clog2(WINDOW+1)-1:0]  mismatch_cnt
);

   localparam int CW = $clog2(WINDOW + 1);
   localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

   localparam logic [IW-1:0] INIT_LOAD   = IW'(INIT_CYCLES - 1);
   localparam logic [CW-1:0] LAST_SAMPLE = CW'(WINDOW - 1);
   localparam logic [CW-1:0] CNT_MAX     = '1;
   localparam logic [CW-1:0] MIS_MIN_C   = CW'(MISMATCH_MIN);
   localparam logic [CW-1:0] LO_MIN_C    = CW'(LO_MIN);
   localparam logic [CW-1:0] HI_MIN_C    = CW'(HI_MIN);

   probe_state_t   state, state_nxt;
   logic [IW-1:0]  init_cnt;
   logic [CW-1:0]  sample_cnt, lo_cnt, hi_cnt, mis_cnt;

   ppu_word_t      word_in, word;
   logic           stable, qualified, mismatch, verdict;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CW'(1);
   endfunction

   assign word_in = '{rd: ppu_rd_in, a13: ppu_a13, not_a13: ppu_not_a13};

   ppu_sync_bus #(
      .WIDTH   ($bits(ppu_word_t)),
      .STAGES  (SYNC_STAGES),
      .RST_VAL (PPU_IDLE)
   ) u_sync (
      .m2     (m2),
      .rst_n  (rst_n),
      .d      (word_in),
      .q      (word),
      .stable (stable)
   );

   // A read only counts once the bus has held still for two synced words
   assign qualified = stable && !word.rd;
   assign mismatch  = qualified && (word.a13 == word.not_a13);

   assign verdict = (mis_cnt >= MIS_MIN_C) && (lo_cnt >= LO_MIN_C) && (hi_cnt >= HI_MIN_C);

   // State register
   always_ff @(posedge m2 or negedge rst_n) begin
      if (!rst_n) state <= ST_INIT;
      else        state <= state_nxt;
   end

   // Init countdown and window counters; cleared while grounding so each probe starts fresh
   always_ff @(posedge m2 or negedge rst_n) begin
      if (!rst_n) begin
         init_cnt   <= INIT_LOAD;
         sample_cnt <= '0;
         lo_cnt     <= '0;
         hi_cnt     <= '0;
         mis_cnt    <= '0;
      end else if (restart || state == ST_INIT) begin
         if (restart)               init_cnt <= INIT_LOAD;
         else if (init_cnt != '0)   init_cnt <= init_cnt - IW'(1);
         sample_cnt <= '0;
         lo_cnt     <= '0;
         hi_cnt     <= '0;
         mis_cnt    <= '0;
      end else if (state == ST_PROBE && qualified) begin
         sample_cnt <= sat_inc(sample_cnt);
         if (word.a13) hi_cnt <= sat_inc(hi_cnt);
         else          lo_cnt <= sat_inc(lo_cnt);
         if (mismatch) mis_cnt <= sat_inc(mis_cnt);
      end
   end

   // Next state and outputs; restart wins over any transition, force overrides the result
   always_comb begin
      state_nxt  = state;
      ground_req = 1'b0;
      done       = 1'b0;
      new_dendy  = 1'b0;
      case (state)
         ST_INIT: begin
            ground_req = 1'b1;
            if (init_cnt == '0) state_nxt = ST_PROBE;
         end
         ST_PROBE: begin
            if (qualified && sample_cnt == LAST_SAMPLE) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            new_dendy = verdict;
         end
         default: state_nxt = ST_INIT;
      endcase
      if (restart) state_nxt = ST_INIT;
      if (is_forced(force_mode)) begin
         done      = 1'b1;
         new_dendy = force_mode[1];
      end
   end

   assign mismatch_cnt = mis_cnt;

endmodule

// File: tb/tb_famiclone_probe.sv
// Self-checking bench for famiclone_probe: table of window scenarios,
// hand sequences for restart / glitch / async reset, and randomized
// windows checked against a read-list reference model.
module tb_famiclone_probe;

   logic       m2 = 1'b0;
   logic       rst_n = 1'b0;
   logic       ppu_rd_in = 1'b1;
   logic       ppu_a13 = 1'b0;
   logic       ppu_not_a13 = 1'b1;
   logic       restart = 1'b0;
   logic [1:0] force_mode = 2'b00;
   logic       ground_req, done, new_dendy;
   logic [4:0] mismatch_cnt;

   int tests = 0;
   int fails = 0;

   always #5 m2 = ~m2;

   famiclone_probe dut (
      .m2           (m2),
      .rst_n        (rst_n),
      .ppu_rd_in    (ppu_rd_in),
      .ppu_a13      (ppu_a13),
      .ppu_not_a13  (ppu_not_a13),
      .restart      (restart),
      .force_mode   (force_mode),
      .ground_req   (ground_req),
      .done         (done),
      .new_dendy    (new_dendy),
      .mismatch_cnt (mismatch_cnt)
   );

   task automatic chk(input string name, input logic [31:0] got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // one m2 cycle with the given pins; returns 1 time unit after the edge
   task automatic cyc(input logic rd, input logic a, input logic na);
      ppu_rd_in = rd; ppu_a13 = a; ppu_not_a13 = na;
      @(posedge m2); #1;
   endtask

   // a PPU read: /RD low for two cycles, then a gap with /RD high
   task automatic rd_op(input logic a, input logic na, input int gap);
      cyc(1'b0, a, na); cyc(1'b0, a, na);
      for (int i = 0; i < gap; i++) cyc(1'b1, a, na);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; restart = 1'b0; force_mode = 2'b00;
      ppu_rd_in = 1'b1; ppu_a13 = 1'b0; ppu_not_a13 = 1'b1;
      #2;
      chk("rst_ground", ground_req, 1);
      chk("rst_done", done, 0);
      chk("rst_new_dendy", new_dendy, 0);
      chk("rst_mismatch", mismatch_cnt, 0);
      @(posedge m2); #1;
      rst_n = 1'b1;
   endtask

   // counts m2 edges until grounding drops, bounded
   task automatic wait_ground_low(output int n);
      n = 0;
      while (ground_req && n < 40) begin
         cyc(1'b1, 1'b0, 1'b1);
         n++;
      end
   endtask

   // pat: 0 alternating A13, 1 all A13=1, 2 all A13=0; mism: /A13 equals A13
   task automatic run_window(input int pat, input logic mism, input int first, input int count);
      logic a, na;
      for (int i = first; i < first + count; i++) begin
         a  = (pat == 0) ? i[0] : (pat == 1);
         na = mism ? a : ~a;
         rd_op(a, na, 2);
      end
   endtask

   typedef struct {
      int         pat;
      logic       mism;
      logic [1:0] fm;
      int         exp_nd;
      int         exp_mis;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int n;
      int exp_nd;

      tbl[0] = '{pat: 0, mism: 1'b0, fm: 2'b00, exp_nd: 0, exp_mis: 0};
      tbl[1] = '{pat: 0, mism: 1'b1, fm: 2'b00, exp_nd: 1, exp_mis: 16};
      tbl[2] = '{pat: 1, mism: 1'b1, fm: 2'b00, exp_nd: 0, exp_mis: 16};
      tbl[3] = '{pat: 2, mism: 1'b1, fm: 2'b00, exp_nd: 0, exp_mis: 16};
      tbl[4] = '{pat: 0, mism: 1'b0, fm: 2'b10, exp_nd: 1, exp_mis: 0};
      tbl[5] = '{pat: 0, mism: 1'b1, fm: 2'b01, exp_nd: 0, exp_mis: 16};
      tbl[6] = '{pat: 0, mism: 1'b1, fm: 2'b11, exp_nd: 1, exp_mis: 16};

      // idle PPU after reset: exact grounding length, then no done
      do_reset();
      wait_ground_low(n);
      chk("init_len_idle", n, 15);
      for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 1'b1);
      chk("idle_ground", ground_req, 0);
      chk("idle_done", done, 0);

      // scenario table
      for (int v = 0; v < 7; v++) begin
         do_reset();
         force_mode = tbl[v].fm;
         wait_ground_low(n);
         chk("tbl_init_len", n, 15);
         run_window(tbl[v].pat, tbl[v].mism, 0, 15);
         if (tbl[v].fm == 2'b00 || tbl[v].fm == 2'b11) chk("tbl_done_early", done, 0);
         run_window(tbl[v].pat, tbl[v].mism, 15, 1);
         chk("tbl_done", done, 1);
         chk("tbl_new_dendy", new_dendy, tbl[v].exp_nd);
         chk("tbl_mismatch", mismatch_cnt, tbl[v].exp_mis);
         for (int i = 0; i < 8; i++) rd_op(1'b1, 1'b1, 2);
         chk("tbl_hold_mis", mismatch_cnt, tbl[v].exp_mis);
      end

      // restart after 8 mismatching samples, then full matching re-probe
      do_reset();
      wait_ground_low(n);
      run_window(0, 1'b1, 0, 8);
      chk("rs_mis8", mismatch_cnt, 8);
      chk("rs_done_pre", done, 0);
      restart = 1'b1;
      @(posedge m2); #1;
      restart = 1'b0;
      chk("rs_ground", ground_req, 1);
      chk("rs_done", done, 0);
      chk("rs_mis_clr", mismatch_cnt, 0);
      wait_ground_low(n);
      chk("rs_init_len", n, 15);
      run_window(0, 1'b0, 0, 16);
      chk("rs2_done", done, 1);
      chk("rs2_new_dendy", new_dendy, 0);
      chk("rs2_mis", mismatch_cnt, 0);

      // restart from DONE clears the result
      restart = 1'b1;
      @(posedge m2); #1;
      restart = 1'b0;
      chk("rsd_done", done, 0);
      chk("rsd_ground", ground_req, 1);

      // forced new_dendy during INIT: immediate, grounding unaffected
      do_reset();
      force_mode = 2'b10;
      #1;
      chk("frc_done", done, 1);
      chk("frc_nd", new_dendy, 1);
      chk("frc_ground", ground_req, 1);
      wait_ground_low(n);
      chk("frc_init_len", n, 15);
      force_mode = 2'b00;
      #1;
      chk("frc_release", done, 0);

      // A13 toggling every edge: never stable, never counted
      do_reset();
      wait_ground_low(n);
      for (int i = 0; i < 200; i++) cyc(1'b0, i[0], i[0]);
      chk("glt_done", done, 0);
      chk("glt_mis", mismatch_cnt, 0);
      chk("glt_ground", ground_req, 0);

      // async reset mid-probe
      run_window(0, 1'b1, 0, 5);
      chk("ar_mis5", mismatch_cnt, 5);
      do_reset();
      wait_ground_low(n);
      chk("ar_init_len", n, 15);

      // randomized windows against a read-list model
      for (int it = 0; it < 24; it++) begin
         int         pm, mis, lo, hi;
         logic [1:0] fm;
         logic       a, na;
         pm = $urandom_range(0, 100);
         fm = 2'($urandom_range(0, 3));
         mis = 0; lo = 0; hi = 0;
         do_reset();
         force_mode = fm;
         wait_ground_low(n);
         for (int r = 0; r < 16; r++) begin
            a  = 1'($urandom_range(0, 1));
            na = ($urandom_range(0, 99) < pm) ? a : ~a;
            if (a == na) mis++;
            if (a) hi++; else lo++;
            if ($urandom_range(0, 3) == 0) begin
               cyc(1'b0, ~a, na);
               cyc(1'b1, ~a, na);
            end
            rd_op(a, na, $urandom_range(2, 4));
         end
         if (fm == 2'b01)      exp_nd = 0;
         else if (fm == 2'b10) exp_nd = 1;
         else                  exp_nd = (mis >= 3 && lo >= 1 && hi >= 1) ? 1 : 0;
         chk("rnd_done", done, 1);
         chk("rnd_new_dendy", new_dendy, exp_nd);
         chk("rnd_mis", mismatch_cnt, mis);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
